// File: rtl/cacheline_mem_arbiter_pkg.sv
// cache_types: shared FSM/owner encodings and line geometry for the cacheline memory arbiter (CACHE_ARB_PREFETCH_EN adds the prefetch owner)
package cache_types;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
`ifdef CACHE_ARB_PREFETCH_EN
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC, OWN_PF} arb_owner_t;
`else
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} arb_owner_t;
`endif
  function automatic int line_offset_bits(input int cls);
    return $clog2(cls / 8);
  endfunction
  localparam int LINE_OFFSET_BITS = line_offset_bits(256);
endpackage

// File: rtl/cacheline_mem_arbiter_picker.sv
// mem_arb_picker: combinational 2-way round-robin demand picker (ic/dc) with prefetch as lowest-priority fallback; rr_dc=1 favours dc on contention; pf_req exists only with CACHE_ARB_PREFETCH_EN
module mem_arb_picker
  import cache_types::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
`ifdef CACHE_ARB_PREFETCH_EN
  input  logic       pf_req,
`endif
  input  logic       rr_dc,
  output arb_owner_t grant
);
  arb_owner_t fallback;
`ifdef CACHE_ARB_PREFETCH_EN
  assign fallback = pf_req ? OWN_PF : OWN_NONE;
`else
  assign fallback = OWN_NONE;
`endif
  always_comb begin
    grant = (ic_req && dc_req) ? (rr_dc ? OWN_DC : OWN_IC) :
            ic_req ? OWN_IC : dc_req ? OWN_DC : fallback;
  end
endmodule

// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter: serialises icache demand, icache prefetch and dcache line transactions onto one memory port.
// Ports: ic_read/ic_addr/ic_resp, pf_read/pf_addr/pf_resp (active only with CACHE_ARB_PREFETCH_EN), dc_read/dc_write/dc_addr/dc_wdata/dc_resp,
// mem_read/mem_write/mem_addr/mem_wdata strobes to memory, mem_resp/mem_rdata back, mem_rdata_o broadcast to requesters.
module cacheline_mem_arbiter
  import cache_types::*;
#(
  parameter int CACHE_LINE_SIZE = 256,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ic_read,
  input  logic [ADDR_WIDTH-1:0]      ic_addr,
  output logic                       ic_resp,
  input  logic                       pf_read,
  input  logic [ADDR_WIDTH-1:0]      pf_addr,
  output logic                       pf_resp,
  input  logic                       dc_read,
  input  logic                       dc_write,
  input  logic [ADDR_WIDTH-1:0]      dc_addr,
  input  logic [CACHE_LINE_SIZE-1:0] dc_wdata,
  output logic                       dc_resp,
  output logic [CACHE_LINE_SIZE-1:0] mem_rdata_o,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  input  logic                       mem_resp,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata
);
  localparam int OFF = line_offset_bits(CACHE_LINE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);
  arb_state_t state, state_nx;
  arb_owner_t owner, grant;
  logic rr_dc, is_write, dc_req, done;
  logic [ADDR_WIDTH-1:0] grant_addr;
  assign dc_req = dc_read || dc_write;
  mem_arb_picker u_picker (
    .ic_req (ic_read),
    .dc_req (dc_req),
`ifdef CACHE_ARB_PREFETCH_EN
    .pf_req (pf_read),
`endif
    .rr_dc  (rr_dc),
    .grant  (grant)
  );
`ifdef CACHE_ARB_PREFETCH_EN
  assign grant_addr = grant == OWN_DC ? dc_addr : grant == OWN_PF ? pf_addr : ic_addr;
`else
  logic unused_pf;
  assign unused_pf  = pf_read ^ (^pf_addr);
  assign grant_addr = grant == OWN_DC ? dc_addr : ic_addr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_NONE;
      rr_dc     <= 1'b0;
      is_write  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && grant != OWN_NONE) begin
        owner    <= grant;
        mem_addr <= grant_addr & ADDR_MASK;
        is_write <= grant == OWN_DC && dc_write;
        if (grant == OWN_DC) mem_wdata <= dc_wdata;
        // Prefetch grants leave the demand rotation untouched.
        if (grant == OWN_IC) rr_dc <= 1'b1;
        if (grant == OWN_DC) rr_dc <= 1'b0;
      end
    end
  end
  always_comb begin
    done      = state == ARB_WAIT && mem_resp;
    state_nx  = state == ARB_IDLE  ? (grant != OWN_NONE ? ARB_ISSUE : ARB_IDLE) :
                state == ARB_ISSUE ? ARB_WAIT : (mem_resp ? ARB_IDLE : ARB_WAIT);
    mem_read  = state == ARB_ISSUE && !is_write;
    mem_write = state == ARB_ISSUE && is_write;
    ic_resp   = done && owner == OWN_IC;
    dc_resp   = done && owner == OWN_DC;
`ifdef CACHE_ARB_PREFETCH_EN
    pf_resp   = done && owner == OWN_PF;
`else
    pf_resp   = 1'b0;
`endif
  end
  assign mem_rdata_o = mem_rdata;
  a_ic_held: assert property (@(posedge clk) disable iff (rst)
    (state != ARB_IDLE && owner == OWN_IC) |-> ic_read);
  a_dc_held: assert property (@(posedge clk) disable iff (rst)
    (state != ARB_IDLE && owner == OWN_DC) |-> dc_req);
`ifdef CACHE_ARB_PREFETCH_EN
  a_pf_held: assert property (@(posedge clk) disable iff (rst)
    (state != ARB_IDLE && owner == OWN_PF) |-> pf_read);
`endif
  a_dc_excl: assert property (@(posedge clk) disable iff (rst) !(dc_read && dc_write));
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb_cacheline_mem_arbiter: directed self-checking bench for cacheline_mem_arbiter
module tb_cacheline_mem_arbiter;
  localparam int CLS = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic ic_read = 0, pf_read = 0, dc_read = 0, dc_write = 0, mem_resp = 0;
  logic [31:0] ic_addr = 0, pf_addr = 0, dc_addr = 0;
  logic [CLS-1:0] dc_wdata = '0, mem_rdata = '0;
  logic ic_resp, pf_resp, dc_resp, mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [CLS-1:0] mem_rdata_o, mem_wdata;
  int checks = 0, failures = 0;
  cacheline_mem_arbiter #(.CACHE_LINE_SIZE(CLS), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_resp(ic_resp),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_resp(pf_resp),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_resp(dc_resp),
    .mem_rdata_o(mem_rdata_o), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [CLS-1:0] got, input logic [CLS-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask
  task automatic issue(input string tag, input int exp_n, input logic [31:0] addr, input logic wr,
                       input logic [CLS-1:0] wdata);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      step;
      n++;
    end
    check({tag, " wait"}, CLS'(n), CLS'(exp_n));
    check({tag, " addr"}, CLS'(mem_addr), CLS'(addr));
    check({tag, " strobe"}, CLS'({mem_read, mem_write}), CLS'({!wr, wr}));
    if (wr) check({tag, " wdata"}, mem_wdata, wdata);
  endtask
  task automatic respond(input string tag, input int lat, input logic [CLS-1:0] rdata, input logic [2:0] exp_resp);
    step;
    mem_resp = 1'b0;
    check({tag, " strobe_off"}, CLS'({mem_read, mem_write}), '0);
    repeat (lat) step;
    mem_resp = 1'b1;
    mem_rdata = rdata;
    #1;
    check({tag, " resp"}, CLS'({ic_resp, dc_resp, pf_resp}), CLS'(exp_resp));
    check({tag, " rdata"}, mem_rdata_o, rdata);
    step;
    mem_resp = 1'b0;
    check({tag, " resp_off"}, CLS'({ic_resp, dc_resp, pf_resp}), '0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset;
    check("reset strobes", CLS'({mem_read, mem_write, ic_resp, dc_resp, pf_resp}), '0);
    check("reset addr", CLS'(mem_addr), '0);
    check("reset wdata", mem_wdata, '0);
    ic_addr = 32'h0000_1234;
    ic_read = 1'b1;
    issue("t1", 1, 32'h0000_1220, 1'b0, '0);
    mem_resp = 1'b1;
    #1;
    check("t1 spurious_issue", CLS'({ic_resp, dc_resp, pf_resp}), '0);
    respond("t1", 3, {8{32'hDEAD_BEEF}}, 3'b100);
    ic_read = 1'b0;
    ic_read = 1'b1;
    dc_read = 1'b1;
    ic_addr = 32'h0000_0100;
    dc_addr = 32'h0000_0200;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      issue("t2 ic", 1, 32'h0000_0100, 1'b0, '0);
      respond("t2 ic", 1, CLS'(i + 1), 3'b100);
      issue("t2 dc", 1, 32'h0000_0200, 1'b0, '0);
      respond("t2 dc", 1, CLS'(i + 16), 3'b010);
    end
    ic_read = 1'b0;
    dc_read = 1'b0;
    do_reset;
    dc_read = 1'b1;
    issue("t7 dc", 1, 32'h0000_0200, 1'b0, '0);
    respond("t7 dc", 0, CLS'(7), 3'b010);
    ic_read = 1'b1;
    issue("t7 ic", 1, 32'h0000_0100, 1'b0, '0);
    respond("t7 ic", 0, CLS'(8), 3'b100);
    ic_read = 1'b0;
    dc_read = 1'b0;
    do_reset;
    dc_write = 1'b1;
    dc_addr = 32'h8000_0040;
    dc_wdata = {32{8'hA5}};
    issue("t3", 1, 32'h8000_0040, 1'b1, {32{8'hA5}});
    respond("t3", 2, CLS'(9), 3'b010);
    dc_write = 1'b0;
    do_reset;
    ic_addr = 32'h0000_4000;
    ic_read = 1'b1;
    issue("t5", 1, 32'h0000_4000, 1'b0, '0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    ic_read = 1'b0;
    check("t5 reset addr", CLS'(mem_addr), '0);
    step;
    step;
    mem_resp = 1'b1;
    #1;
    check("t5 late resp", CLS'({ic_resp, dc_resp, pf_resp}), '0);
    step;
    mem_resp = 1'b0;
    check("t5 idle", CLS'({mem_read, mem_write}), '0);
    ic_addr = 32'h0000_405F;
    ic_read = 1'b1;
    issue("t5 next", 1, 32'h0000_4040, 1'b0, '0);
    respond("t5 next", 1, CLS'(10), 3'b100);
    ic_read = 1'b0;
`ifdef CACHE_ARB_PREFETCH_EN
    ic_addr = 32'h0000_1000;
    pf_addr = 32'h0000_3000;
    do_reset;
    ic_read = 1'b1;
    pf_read = 1'b1;
    issue("t4 ic", 1, 32'h0000_1000, 1'b0, '0);
    respond("t4 ic", 1, CLS'(11), 3'b100);
    ic_read = 1'b0;
    issue("t4 pf", 1, 32'h0000_3000, 1'b0, '0);
    respond("t4 pf", 1, CLS'(12), 3'b001);
    pf_addr = 32'h0000_3040;
    issue("t4 pf2", 1, 32'h0000_3040, 1'b0, '0);
    dc_addr = 32'h0000_5000;
    dc_wdata = {32{8'h3C}};
    dc_write = 1'b1;
    respond("t4 pf2", 2, CLS'(13), 3'b001);
    pf_read = 1'b0;
    issue("t4 dc", 1, 32'h0000_5000, 1'b1, {32{8'h3C}});
    respond("t4 dc", 1, CLS'(14), 3'b010);
    dc_write = 1'b0;
`else
    begin
      int busy = 0;
      pf_read = 1'b1;
      pf_addr = 32'h0000_3000;
      do_reset;
      for (int i = 0; i < 10; i++) begin
        mem_resp = (i == 4);
        #1;
        busy += int'(mem_read || mem_write || pf_resp || ic_resp || dc_resp);
        step;
      end
      mem_resp = 1'b0;
      check("t6 pf ignored", CLS'(busy), '0);
      ic_addr = 32'h0000_6000;
      ic_read = 1'b1;
      issue("t6 ic", 1, 32'h0000_6000, 1'b0, '0);
      respond("t6 ic", 1, CLS'(15), 3'b100);
      ic_read = 1'b0;
      busy = 0;
      for (int i = 0; i < 5; i++) begin
        busy += int'(mem_read || mem_write || pf_resp);
        step;
      end
      check("t6 idle after", CLS'(busy), '0);
      pf_read = 1'b0;
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
